accumulator_bank: RTL and testbench

- Parametrised result accumulator at the bottom of the systolic array; captures one row of COLS column outputs per accepted beat into a DEPTH-row buffer.
- Optionally sums over several passes (K-tiling), then streams the finished rows out over a valid/ready interface.
- Successor to the fixed 2-entry, 8-bit, capture-only accumulator: adds width/depth/column parameters, signed accumulation, multi-pass control and a drain handshake.

---
 rtl/accumulator_bank.sv | 200 ++++++++++++++++++++
 tb/tb_accumulator_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_bank.sv
// accumulator_bank: DEPTH-row x COLS-column signed accumulator with K-pass tiling and valid/ready row drain.
// Optional saturating adds and the sat_flag output are enabled by defining ACC_SATURATE_EN.
module accumulator_bank #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int DEPTH  = 2,
  parameter int COLS   = 2,
  parameter int PASS_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       acc_mode,
  input  logic [PASS_W-1:0]          num_passes,
  input  logic                       in_valid,
  input  logic [COLS*DATA_W-1:0]     in_data,
  output logic                       in_ready,
  output logic                       full,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS*ACC_W-1:0]      out_data,
  output logic [$clog2(DEPTH)-1:0]   out_row
`ifdef ACC_SATURATE_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(DEPTH - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t                              state_q, state_d;
  logic [DEPTH-1:0][COLS-1:0][ACC_W-1:0] buf_q, buf_d;
  logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [PASS_W-1:0]                   pass_cnt_q, pass_cnt_d;
  logic [PASS_W-1:0]                   passes_q, passes_d;
  logic                                out_valid_q, out_valid_d;
  logic [COLS*ACC_W-1:0]               out_data_q, out_data_d;
  logic [PTR_W-1:0]                    out_row_q, out_row_d;
  logic [ACC_W-1:0]                    ext_s, sum_s;
`ifdef ACC_SATURATE_EN
  logic                                sat_q, sat_d;
`endif

  function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    return ACC_W'(sv);
  endfunction

  // Next-state logic: clear wins, then FILL accepts beats, DRAIN streams rows out.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pass_cnt_d  = pass_cnt_q;
    passes_d    = passes_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    ext_s       = '0;
    sum_s       = '0;
`ifdef ACC_SATURATE_EN
    sat_d       = sat_q;
`endif
    if (clear) begin
      state_d     = FILL;
      buf_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pass_cnt_d  = '0;
      passes_d    = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_row_d   = '0;
`ifdef ACC_SATURATE_EN
      sat_d       = 1'b0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            for (int c = 0; c < COLS; c++) begin
              ext_s = sext(in_data[c*DATA_W +: DATA_W]);
              if (acc_mode) begin
                sum_s = buf_q[wr_ptr_q][c] + ext_s;
`ifdef ACC_SATURATE_EN
                // Signed overflow: operands agree in sign but the wrapped sum does not.
                if ((buf_q[wr_ptr_q][c][ACC_W-1] == ext_s[ACC_W-1]) &&
                    (sum_s[ACC_W-1] != ext_s[ACC_W-1])) begin
                  sum_s = ext_s[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                  sat_d = 1'b1;
                end else begin
                  sum_s = sum_s;
                end
`endif
                buf_d[wr_ptr_q][c] = sum_s;
              end else begin
                buf_d[wr_ptr_q][c] = ext_s;
              end
            end
            if ((wr_ptr_q == '0) && (pass_cnt_q == '0)) begin
              passes_d = (num_passes == '0) ? PASS_W'(1) : num_passes;
            end else begin
              passes_d = passes_q;
            end
            // DEPTH >= 2, so the latching beat is never the final beat and passes_q is valid here.
            if (wr_ptr_q == LAST_ROW) begin
              wr_ptr_d   = '0;
              pass_cnt_d = pass_cnt_q + PASS_W'(1);
              if (pass_cnt_q == (passes_q - PASS_W'(1))) begin
                state_d     = DRAIN;
                rd_ptr_d    = '0;
                out_row_d   = '0;
                out_data_d  = buf_q[0];
                out_valid_d = 1'b1;
              end else begin
                state_d = FILL;
              end
            end else begin
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
          end else begin
            state_d = FILL;
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            if (rd_ptr_q == LAST_ROW) begin
              state_d     = FILL;
              out_valid_d = 1'b0;
              buf_d       = '0;
              wr_ptr_d    = '0;
              rd_ptr_d    = '0;
              pass_cnt_d  = '0;
              passes_d    = '0;
`ifdef ACC_SATURATE_EN
              sat_d       = 1'b0;
`endif
            end else begin
              rd_ptr_d   = rd_ptr_q + PTR_W'(1);
              out_row_d  = rd_ptr_q + PTR_W'(1);
              out_data_d = buf_q[rd_ptr_q + PTR_W'(1)];
            end
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      buf_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pass_cnt_q  <= '0;
      passes_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
`ifdef ACC_SATURATE_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pass_cnt_q  <= pass_cnt_d;
      passes_q    <= passes_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
`ifdef ACC_SATURATE_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == FILL);
  assign full      = (state_q == DRAIN);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
`ifdef ACC_SATURATE_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed self-checking bench for accumulator_bank: default instance plus an ACC_W=8 instance for overflow.
module tb_accumulator_bank;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        acc_mode;
  logic [3:0]  num_passes;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        full;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [0:0]  out_row;

  logic        o_clear;
  logic        o_acc_mode;
  logic [3:0]  o_num_passes;
  logic        o_in_valid;
  logic [15:0] o_in_data;
  logic        o_in_ready;
  logic        o_full;
  logic        o_out_valid;
  logic        o_out_ready;
  logic [15:0] o_out_data;
  logic [0:0]  o_out_row;
`ifdef ACC_SATURATE_EN
  logic        sat_flag;
  logic        o_sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  accumulator_bank dut (
    .clk(clk), .reset(reset), .clear(clear), .acc_mode(acc_mode), .num_passes(num_passes),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .full(full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row)
`ifdef ACC_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  accumulator_bank #(.DATA_W(8), .ACC_W(8), .DEPTH(2), .COLS(2), .PASS_W(4)) dut_ovf (
    .clk(clk), .reset(reset), .clear(o_clear), .acc_mode(o_acc_mode), .num_passes(o_num_passes),
    .in_valid(o_in_valid), .in_data(o_in_data), .in_ready(o_in_ready), .full(o_full),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data), .out_row(o_out_row)
`ifdef ACC_SATURATE_EN
    , .sat_flag(o_sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic beat(input logic [15:0] d, input logic m);
    in_valid = 1'b1; in_data = d; acc_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic obeat(input logic [15:0] d, input logic m);
    o_in_valid = 1'b1; o_in_data = d; o_acc_mode = m;
    @(posedge clk); #1;
    o_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0000_0000) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_row !== 1'b0) begin errors++; $display("FAIL reset_out_row: got %b want 0", out_row); end
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ovf_in_ready: got %b want 1", o_in_ready); end
`ifdef ACC_SATURATE_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
`endif
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_pass;
    num_passes = 4'd1; out_ready = 1'b1;
    beat(16'h0305, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sp_ready_mid: got %b want 1", in_ready); end
    beat(16'h00FE, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL sp_full: got %b want 1", full); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sp_ready_drain: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sp_valid0: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h0003_0005) begin errors++; $display("FAIL sp_row0: got %h want 00030005", out_data); end
    checks++; if (out_row !== 1'b0) begin errors++; $display("FAIL sp_rowidx0: got %b want 0", out_row); end
    @(posedge clk); #1;
    checks++; if (out_data !== 32'h0000_FFFE) begin errors++; $display("FAIL sp_row1: got %h want 0000fffe", out_data); end
    checks++; if (out_row !== 1'b1) begin errors++; $display("FAIL sp_rowidx1: got %b want 1", out_row); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sp_ready_back: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sp_valid_end: got %b want 0", out_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL sp_full_end: got %b want 0", full); end
  endtask

  task automatic test_multi_pass;
    num_passes = 4'd3; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      beat((i < 2) ? 16'h0A0A : 16'h0707, (i >= 2));
      if (i < 5) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mp_ready beat %0d: got %b want 1", i, in_ready); end
      end else begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL mp_full: got %b want 1", full); end
      end
    end
    checks++; if (out_data !== 32'h0018_0018) begin errors++; $display("FAIL mp_row0: got %h want 00180018", out_data); end
    @(posedge clk); #1;
    checks++; if (out_data !== 32'h0018_0018 || out_row !== 1'b1) begin errors++; $display("FAIL mp_row1: got %h row %b want 00180018 row 1", out_data, out_row); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mp_ready_end: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure;
    num_passes = 4'd0; out_ready = 1'b0;
    beat(16'h0102, 1'b0);
    beat(16'h0304, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0001_0002 || out_row !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc %0d: got v=%b d=%h r=%b want v=1 d=00010002 r=0", i, out_valid, out_data, out_row);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    checks++; if (out_data !== 32'h0001_0002) begin errors++; $display("FAIL bp_release_row0: got %h want 00010002", out_data); end
    @(posedge clk); #1;
    checks++; if (out_data !== 32'h0003_0004 || out_row !== 1'b1) begin errors++; $display("FAIL bp_row1: got %h row %b want 00030004 row 1", out_data, out_row); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_end: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
  endtask

  task automatic test_drain_input;
    num_passes = 4'd1; out_ready = 1'b0;
    beat(16'h0908, 1'b0);
    beat(16'h0706, 1'b0);
    in_valid = 1'b1; in_data = 16'h7F7F; acc_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0 || out_data !== 32'h0009_0008) begin errors++; $display("FAIL di_hold cyc %0d: got rdy=%b d=%h want rdy=0 d=00090008", i, in_ready, out_data); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_data !== 32'h0007_0006) begin errors++; $display("FAIL di_row1: got %h want 00070006", out_data); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL di_ready_back: got %b want 1", in_ready); end
    beat(16'h7F01, 1'b1);
    beat(16'h0000, 1'b1);
    checks++; if (out_data !== 32'h007F_0001) begin errors++; $display("FAIL di_zeroed_row0: got %h want 007f0001", out_data); end
    @(posedge clk); #1;
    checks++; if (out_data !== 32'h0000_0000 || out_row !== 1'b1) begin errors++; $display("FAIL di_zeroed_row1: got %h row %b want 0 row 1", out_data, out_row); end
    @(posedge clk); #1;
  endtask

  task automatic test_clear;
    num_passes = 4'd2; out_ready = 1'b1;
    beat(16'h0101, 1'b0);
    beat(16'h0101, 1'b0);
    beat(16'h0101, 1'b1);
    checks++; if (in_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL cl_mid_pass: got rdy=%b full=%b want 1/0", in_ready, full); end
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h5555; acc_mode = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL cl_after: got rdy=%b full=%b v=%b want 1/0/0", in_ready, full, out_valid); end
    num_passes = 4'd1;
    beat(16'h0203, 1'b1);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL cl_one_beat_full: got %b want 0", full); end
    beat(16'h0405, 1'b1);
    checks++; if (full !== 1'b1 || out_data !== 32'h0002_0003) begin errors++; $display("FAIL cl_row0: got full=%b d=%h want 1 00020003", full, out_data); end
    @(posedge clk); #1;
    checks++; if (out_data !== 32'h0004_0005) begin errors++; $display("FAIL cl_row1: got %h want 00040005", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_drain;
    num_passes = 4'd1; out_ready = 1'b0;
    beat(16'h0101, 1'b0);
    beat(16'h0101, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rd_valid_before: got %b want 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || full !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rd_async: got v=%b full=%b rdy=%b want 0/0/1", out_valid, full, in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    o_num_passes = 4'd2; o_out_ready = 1'b1;
    obeat(16'h9C64, 1'b0);
    obeat(16'h9C64, 1'b0);
    obeat(16'h9C64, 1'b1);
    obeat(16'h9C64, 1'b1);
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ov_full: got %b want 1", o_full); end
`ifdef ACC_SATURATE_EN
    checks++; if (o_out_data !== 16'h807F) begin errors++; $display("FAIL ov_row0: got %h want 807f", o_out_data); end
    checks++; if (o_sat_flag !== 1'b1) begin errors++; $display("FAIL ov_sat_flag: got %b want 1", o_sat_flag); end
`else
    checks++; if (o_out_data !== 16'h38C8) begin errors++; $display("FAIL ov_row0: got %h want 38c8", o_out_data); end
`endif
    @(posedge clk); #1;
`ifdef ACC_SATURATE_EN
    checks++; if (o_out_data !== 16'h807F) begin errors++; $display("FAIL ov_row1: got %h want 807f", o_out_data); end
`else
    checks++; if (o_out_data !== 16'h38C8) begin errors++; $display("FAIL ov_row1: got %h want 38c8", o_out_data); end
`endif
    @(posedge clk); #1;
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL ov_ready_back: got %b want 1", o_in_ready); end
`ifdef ACC_SATURATE_EN
    checks++; if (o_sat_flag !== 1'b0) begin errors++; $display("FAIL ov_sat_cleared: got %b want 0", o_sat_flag); end
`endif
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; acc_mode = 1'b0; num_passes = 4'd1;
    in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    o_clear = 1'b0; o_acc_mode = 1'b0; o_num_passes = 4'd1;
    o_in_valid = 1'b0; o_in_data = 16'h0000; o_out_ready = 1'b0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_backpressure();
    test_drain_input();
    test_clear();
    test_reset_mid_drain();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
